// File: rtl/stack_rpn_ctrl.sv
// stack_rpn_ctrl
//   Command-driven RPN sequencer in front of an 8-entry LIFO. It accepts one
//   token at a time on a valid/ready port and drives the stack push/pop
//   strobes. It detects overflow and underflow before touching the stack,
//   and reports the resulting top of stack on a one-cycle result strobe.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready/op/data  command port (op: 0 PUSH 1 DROP 2 DUP 3 PEEK
//                            4 ADD 5 SUB 6 AND 7 XOR)
//   stk_push/pop/din         strobes and write data to the stack
//   stk_dout/valid/full/count  stack status (dout is the combinational top)
//   res_valid/data/err       one-cycle result, err = op rejected
//   err_ovf/err_udf/err_clr  sticky error flags and their clear
module stack_rpn_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [DW-1:0] stk_din,
    input  logic [DW-1:0] stk_dout,
    input  logic          stk_valid,
    input  logic          stk_full,
    input  logic [CW-1:0] stk_count,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          res_err,
    output logic          err_ovf,
    output logic          err_udf,
    input  logic          err_clr
);

    typedef enum logic [2:0] {IDLE, EXEC, POP1, WB, RESP} state_t;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_DROP = 3'd1;
    localparam logic [2:0] OP_DUP  = 3'd2;
    localparam logic [2:0] OP_PEEK = 3'd3;

    typedef struct packed {
        logic [2:0]    op;
        logic [DW-1:0] data;
    } cmd_t;

    state_t        state_q, state_d;
    cmd_t          cmd_q;
    logic [DW-1:0] a_q;        // former top, captured in POP1
    logic          err_q;      // the op was rejected; reported in RESP
    logic          accept, ld_a, set_ovf, set_udf;
    logic          empty, lt2;
    logic [DW-1:0] alu;

    assign empty = (stk_count == '0);
    assign lt2   = (stk_count < CW'(2));

    // In WB stk_dout is the former second entry (B); A was popped in POP1.
    always_comb begin
        unique case (cmd_q.op[1:0])
            2'd0:    alu = stk_dout + a_q;
            2'd1:    alu = stk_dout - a_q;
            2'd2:    alu = stk_dout & a_q;
            default: alu = stk_dout ^ a_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        ld_a      = 1'b0;
        set_ovf   = 1'b0;
        set_udf   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        res_valid = 1'b0;
        res_err   = 1'b0;
        res_data  = '0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = cmd_op[2] ? POP1 : EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                unique case (cmd_q.op)
                    OP_PUSH: begin
                        if (stk_full) set_ovf = 1'b1;
                        else begin
                            stk_push = 1'b1;
                            stk_din  = cmd_q.data;
                        end
                    end
                    OP_DUP: begin
                        if (empty)         set_udf = 1'b1;
                        else if (stk_full) set_ovf = 1'b1;
                        else begin
                            stk_push = 1'b1;
                            stk_din  = stk_dout;
                        end
                    end
                    OP_DROP: begin
                        if (empty) set_udf = 1'b1;
                        else       stk_pop = 1'b1;
                    end
                    OP_PEEK: begin
                        if (empty) set_udf = 1'b1;
                    end
                    default: ;
                endcase
            end
            POP1: begin
                if (lt2) begin
                    set_udf = 1'b1;
                    state_d = RESP;
                end else begin
                    stk_pop = 1'b1;
                    ld_a    = 1'b1;
                    state_d = WB;
                end
            end
            WB: begin
                // push+pop together replaces the top in place
                stk_push = 1'b1;
                stk_pop  = 1'b1;
                stk_din  = alu;
                state_d  = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                res_err   = err_q;
                res_data  = (!err_q && stk_valid) ? stk_dout : '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            a_q     <= '0;
            err_q   <= 1'b0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q <= '{op: cmd_op, data: cmd_data};
                err_q <= 1'b0;
            end
            if (ld_a) a_q <= stk_dout;
            if (set_ovf || set_udf) err_q <= 1'b1;
            // a new error wins over a clear in the same cycle
            if (set_ovf)      err_ovf <= 1'b1;
            else if (err_clr) err_ovf <= 1'b0;
            if (set_udf)      err_udf <= 1'b1;
            else if (err_clr) err_udf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_rpn_ctrl.sv
module tb_stack_rpn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_data = '0;
    logic       stk_push, stk_pop;
    logic [7:0] stk_din, stk_dout;
    logic       stk_valid, stk_full;
    logic [3:0] stk_count;
    logic       res_valid, res_err, err_ovf, err_udf;
    logic [7:0] res_data;
    logic       err_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stack_rpn_ctrl #(.DW(8), .DEPTH(8), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_valid(stk_valid), .stk_full(stk_full), .stk_count(stk_count),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr)
    );

    // reference 8 x 8 LIFO sharing rst
    logic [7:0] mem [8];
    logic [3:0] cnt;
    assign stk_count = cnt;
    assign stk_valid = (cnt != 0);
    assign stk_full  = (cnt == 4'd8);
    assign stk_dout  = (cnt != 0) ? mem[3'(cnt - 4'd1)] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (stk_push && stk_pop && cnt != 0) mem[3'(cnt - 4'd1)] <= stk_din;
        else if (stk_push && !stk_pop && cnt < 8) begin
            mem[cnt[2:0]] <= stk_din;
            cnt <= cnt + 4'd1;
        end else if (stk_pop && !stk_push && cnt != 0) cnt <= cnt - 4'd1;
    end

    localparam logic [2:0] PUSH = 0, DROP = 1, DUP = 2, PEEK = 3,
                           ADD = 4, SUB = 5, AND_ = 6, XOR_ = 7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // issue one command; returns result fields, latency and strobes seen
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d,
                          output logic [7:0] rd, output logic re, output int lat,
                          output logic sp, output logic spop);
        int  w;
        logic got;
        rd = '0; re = 1'b0; lat = 0; sp = 1'b0; spop = 1'b0; got = 1'b0; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
        if (!cmd_ready) check("ready_timeout", 0, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk); #1;
        // scramble the command bus: only the accept-edge sample may matter
        cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~d;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            sp   = sp | stk_push;
            spop = spop | stk_pop;
            if (res_valid) begin got = 1'b1; lat = i; rd = res_data; re = res_err; end
        end
        if (!got) check("res_timeout", 0, 1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] d,
                       input logic [7:0] exp_d, input logic exp_e);
        logic [7:0] rd; logic re, sp, spop; int lat;
        do_cmd(op, d, rd, re, lat, sp, spop);
        check({tag, "_data"}, rd, exp_d);
        check({tag, "_err"}, re, exp_e);
        check({tag, "_lat"}, lat, op[2] ? 3 : 2);
    endtask

    logic [7:0] rd;
    logic re, sp, spop;
    int lat;

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_resv", res_valid, 0);
        check("rst_strobes", {stk_push, stk_pop}, 0);
        check("rst_errs", {res_err, err_ovf, err_udf}, 0);
        check("rst_resdata", res_data, 0);

        // basic add
        run("push12", PUSH, 8'h12, 8'h12, 0);
        run("push34", PUSH, 8'h34, 8'h34, 0);
        run("add46", ADD, 8'h00, 8'h46, 0);
        @(negedge clk);
        check("add_count", stk_count, 1);

        // sub and wrapping add
        do_reset();
        run("push05", PUSH, 8'h05, 8'h05, 0);
        run("push07", PUSH, 8'h07, 8'h07, 0);
        run("subFE", SUB, 8'h00, 8'hFE, 0);
        run("pushF0", PUSH, 8'hF0, 8'hF0, 0);
        run("push20", PUSH, 8'h20, 8'h20, 0);
        run("add10", ADD, 8'h00, 8'h10, 0);
        @(negedge clk);
        check("sub_count", stk_count, 2);

        // overflow
        do_reset();
        for (int i = 1; i <= 7; i++) run("fill", PUSH, 8'(i), 8'(i), 0);
        @(negedge clk);
        check("count7", stk_count, 7);
        run("push8", PUSH, 8'h08, 8'h08, 0);
        do_cmd(PUSH, 8'h09, rd, re, lat, sp, spop);
        check("ovf_err", re, 1);
        check("ovf_data", rd, 0);
        check("ovf_nopush", sp, 0);
        check("ovf_flag", err_ovf, 1);
        run("peek08", PEEK, 8'h00, 8'h08, 0);
        @(negedge clk);
        check("ovf_count", stk_count, 8);

        // binary underflow
        do_reset();
        check("rst_clears_ovf", err_ovf, 0);
        run("pushAA", PUSH, 8'hAA, 8'hAA, 0);
        do_cmd(ADD, 8'h00, rd, re, lat, sp, spop);
        check("udf_err", re, 1);
        check("udf_data", rd, 0);
        check("udf_nopop", spop, 0);
        check("udf_lat", lat, 2);
        check("udf_flag", err_udf, 1);
        run("peekAA", PEEK, 8'h00, 8'hAA, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("udf_clr", err_udf, 0);

        // dup / xor / drop
        do_reset();
        run("push3C", PUSH, 8'h3C, 8'h3C, 0);
        run("dup3C", DUP, 8'h00, 8'h3C, 0);
        run("xor00", XOR_, 8'h00, 8'h00, 0);
        run("drop_last", DROP, 8'h00, 8'h00, 0);
        check("drop_noerr_flag", err_udf, 0);
        // clear held through a failing op: set must win
        err_clr = 1'b1;
        run("drop_empty", DROP, 8'h00, 8'h00, 1);
        check("set_over_clr", err_udf, 1);
        err_clr = 1'b0;
        @(negedge clk);
        check("empty_count", stk_count, 0);

        // reset during WB of an AND
        do_reset();
        run("push01", PUSH, 8'h01, 8'h01, 0);
        run("push02", PUSH, 8'h02, 8'h02, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = AND_; cmd_data = 8'h00;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("and_pop1", {stk_push, stk_pop}, 2'b01);
        @(negedge clk);
        check("and_wb", {stk_push, stk_pop}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_strobes", {stk_push, stk_pop}, 0);
        check("mid_rst_resv", res_valid, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_count", stk_count, 0);
        @(negedge clk);
        check("mid_rst_resv2", res_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
